// File: rtl/axi_wr_burst_sched.sv
`default_nettype none
// ============================================================================
// axi_wr_burst_sched : word FIFO -> AXI4 INCR write bursts, one outstanding.
// Optional perf counters under AXI_WR_SCHED_PERF_EN.           Rev 1.0
// ============================================================================
module axi_wr_burst_sched #(
  parameter int unsigned            ADDR_WIDTH   = 32,
  parameter int unsigned            DATA_WIDTH   = 128,
  parameter int unsigned            BURST_LEN    = 16,
  parameter int unsigned            CNT_WIDTH    = 5,
  parameter logic [ADDR_WIDTH-1:0]  BASE_ADDR    = '0,
  parameter logic [ADDR_WIDTH-1:0]  REGION_BYTES = ADDR_WIDTH'(32'h0010_0000)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      enable,
  input  logic                      flush,
  input  logic [DATA_WIDTH-1:0]     fifo_dout,
  input  logic                      fifo_empty,
  input  logic [CNT_WIDTH-1:0]      fifo_count,
  output logic                      fifo_rd_en,
  output logic [ADDR_WIDTH-1:0]     m_awaddr,
  output logic [7:0]                m_awlen,
  output logic [2:0]                m_awsize,
  output logic [1:0]                m_awburst,
  output logic                      m_awvalid,
  input  logic                      m_awready,
  output logic [DATA_WIDTH-1:0]     m_wdata,
  output logic [DATA_WIDTH/8-1:0]   m_wstrb,
  output logic                      m_wlast,
  output logic                      m_wvalid,
  input  logic                      m_wready,
  input  logic [1:0]                m_bresp,
  input  logic                      m_bvalid,
  output logic                      m_bready,
  output logic                      busy,
  output logic                      wr_err,
  output logic [31:0]               perf_bursts,
  output logic [31:0]               perf_beats
);

  localparam int unsigned SIZE_LOG2 = $clog2(DATA_WIDTH / 8);
  localparam logic [ADDR_WIDTH-1:0] REGION_END = BASE_ADDR + REGION_BYTES;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ADDR = 2'd1,
    S_DATA = 2'd2,
    S_RESP = 2'd3
  } state_t;

  state_t                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d, awaddr_q, awaddr_d;
  logic [7:0]              awlen_q, awlen_d, beat_q, beat_d;
  logic [8:0]              len_q, len_d;
  logic                    awvalid_q, awvalid_d, bready_q, bready_d;
  logic                    busy_q, busy_d, wr_err_q, wr_err_d;

  logic [12:0]             bytes_to_4k;
  logic [8:0]              beats_to_4k;
  logic [31:0]             cnt_ext, new_len;
  logic                    start, w_hs, last_beat;
  logic [ADDR_WIDTH-1:0]   addr_next;
  logic                    unused_bresp0;

  assign unused_bresp0 = m_bresp[0];

  // A burst never crosses a 4 KB page, so clip to the beats left in this page.
  assign bytes_to_4k = 13'h1000 - {1'b0, addr_q[11:0]};
  assign beats_to_4k = 9'(bytes_to_4k >> SIZE_LOG2);
  assign cnt_ext     = 32'(fifo_count);

  always_comb begin
    new_len = cnt_ext;
    if (new_len > BURST_LEN)             new_len = BURST_LEN;
    if (new_len > 32'(beats_to_4k))      new_len = 32'(beats_to_4k);
  end

  assign start     = enable && ((cnt_ext >= BURST_LEN) || (flush && !fifo_empty))
                     && (new_len != 32'd0);
  assign m_wvalid  = (state_q == S_DATA) && !fifo_empty;
  assign w_hs      = m_wvalid && m_wready;
  assign last_beat = ({1'b0, beat_q} == (len_q - 9'd1));
  assign addr_next = addr_q + (ADDR_WIDTH'(len_q) << SIZE_LOG2);

  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    awaddr_d = awaddr_q;
    awlen_d  = awlen_q;
    len_d    = len_q;
    beat_d   = beat_q;
    wr_err_d = wr_err_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          len_d    = new_len[8:0];
          awaddr_d = addr_q;
          awlen_d  = 8'(new_len - 32'd1);
          beat_d   = '0;
          state_d  = S_ADDR;
        end
      end
      S_ADDR: begin
        if (m_awready) state_d = S_DATA;
      end
      S_DATA: begin
        if (w_hs) begin
          beat_d = beat_q + 8'd1;
          if (last_beat) state_d = S_RESP;
        end
      end
      S_RESP: begin
        if (m_bvalid) begin
          state_d = S_IDLE;
          if (m_bresp[1]) wr_err_d = 1'b1;
          addr_d = (addr_next == REGION_END) ? BASE_ADDR : addr_next;
        end
      end
      default: state_d = S_IDLE;
    endcase
    awvalid_d = (state_d == S_ADDR);
    bready_d  = (state_d == S_RESP);
    busy_d    = (state_d != S_IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      addr_q    <= BASE_ADDR;
      awaddr_q  <= '0;
      awlen_q   <= '0;
      len_q     <= '0;
      beat_q    <= '0;
      awvalid_q <= 1'b0;
      bready_q  <= 1'b0;
      busy_q    <= 1'b0;
      wr_err_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      awaddr_q  <= awaddr_d;
      awlen_q   <= awlen_d;
      len_q     <= len_d;
      beat_q    <= beat_d;
      awvalid_q <= awvalid_d;
      bready_q  <= bready_d;
      busy_q    <= busy_d;
      wr_err_q  <= wr_err_d;
    end
  end

  assign fifo_rd_en = w_hs;
  assign m_awaddr   = awaddr_q;
  assign m_awlen    = awlen_q;
  assign m_awsize   = 3'(SIZE_LOG2);
  assign m_awburst  = 2'b01;
  assign m_awvalid  = awvalid_q;
  assign m_wdata    = fifo_dout;
  assign m_wstrb    = '1;
  assign m_wlast    = (state_q == S_DATA) && last_beat;
  assign m_bready   = bready_q;
  assign busy       = busy_q;
  assign wr_err     = wr_err_q;

`ifdef AXI_WR_SCHED_PERF_EN
  logic [31:0] perf_bursts_q, perf_bursts_d, perf_beats_q, perf_beats_d;

  always_comb begin
    perf_bursts_d = perf_bursts_q;
    perf_beats_d  = perf_beats_q;
    if (bready_q && m_bvalid) begin
      perf_bursts_d = perf_bursts_q + 32'd1;
      perf_beats_d  = perf_beats_q + 32'(len_q);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_bursts_q <= '0;
      perf_beats_q  <= '0;
    end else begin
      perf_bursts_q <= perf_bursts_d;
      perf_beats_q  <= perf_beats_d;
    end
  end

  assign perf_bursts = perf_bursts_q;
  assign perf_beats  = perf_beats_q;
`else
  assign perf_bursts = '0;
  assign perf_beats  = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_axi_wr_burst_sched.sv
`default_nettype none
// ============================================================================
// tb_axi_wr_burst_sched : directed/randomised bench with a burst-level model.
// Rev 1.0
// ============================================================================
module tb_axi_wr_burst_sched;

  localparam logic [31:0] BASE   = 32'h0000_0000;
  localparam logic [31:0] REGION = 32'h0000_2000;

  logic         clk, rst_n, enable, flush;
  logic [127:0] fifo_dout;
  logic         fifo_empty;
  logic [4:0]   fifo_count;
  logic         fifo_rd_en;
  logic [31:0]  m_awaddr;
  logic [7:0]   m_awlen;
  logic [2:0]   m_awsize;
  logic [1:0]   m_awburst;
  logic         m_awvalid, m_awready;
  logic [127:0] m_wdata;
  logic [15:0]  m_wstrb;
  logic         m_wlast, m_wvalid, m_wready;
  logic [1:0]   m_bresp;
  logic         m_bvalid, m_bready, busy, wr_err;
  logic [31:0]  perf_bursts, perf_beats;

  axi_wr_burst_sched #(
    .ADDR_WIDTH(32), .DATA_WIDTH(128), .BURST_LEN(16), .CNT_WIDTH(5),
    .BASE_ADDR(BASE), .REGION_BYTES(REGION)
  ) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .flush(flush),
    .fifo_dout(fifo_dout), .fifo_empty(fifo_empty), .fifo_count(fifo_count),
    .fifo_rd_en(fifo_rd_en),
    .m_awaddr(m_awaddr), .m_awlen(m_awlen), .m_awsize(m_awsize),
    .m_awburst(m_awburst), .m_awvalid(m_awvalid), .m_awready(m_awready),
    .m_wdata(m_wdata), .m_wstrb(m_wstrb), .m_wlast(m_wlast),
    .m_wvalid(m_wvalid), .m_wready(m_wready),
    .m_bresp(m_bresp), .m_bvalid(m_bvalid), .m_bready(m_bready),
    .busy(busy), .wr_err(wr_err),
    .perf_bursts(perf_bursts), .perf_beats(perf_beats)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Model state: phase 0 idle, 1 address, 2 data, 3 response.
  int           phase, exp_len, beats, burst_idx, err_on_burst;
  logic [31:0]  m_addr;
  bit           exp_err;
  int           exp_bursts, exp_beats;
  logic [127:0] q[$];
  logic [31:0]  word_seq;
  int           feed_left, stall_at, stall_left, aw_wait;
  int           aw_mode, w_mode, b_rand;
  bit           wtog;
  int           rd_en_cnt;
  logic [31:0]  aw_addr_log[$];
  int           aw_len_log[$];

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset(input bit clear_fifo);
    phase = 0; exp_len = 0; beats = 0; burst_idx = 0; m_addr = BASE;
    exp_err = 0; exp_bursts = 0; exp_beats = 0; aw_wait = 0;
    rd_en_cnt = 0; aw_addr_log.delete(); aw_len_log.delete();
    stall_left = 0; stall_at = -1; err_on_burst = -1;
    if (clear_fifo) begin q.delete(); word_seq = 0; feed_left = 0; end
  endtask

  task automatic check_reset_outputs(input string pfx);
    check({pfx, "_awvalid"}, m_awvalid, 1'b0);
    check({pfx, "_wvalid"},  m_wvalid, 1'b0);
    check({pfx, "_bready"},  m_bready, 1'b0);
    check({pfx, "_wlast"},   m_wlast, 1'b0);
    check({pfx, "_rd_en"},   fifo_rd_en, 1'b0);
    check({pfx, "_busy"},    busy, 1'b0);
    check({pfx, "_wr_err"},  wr_err, 1'b0);
    check({pfx, "_awlen"},   m_awlen, 8'd0);
    check({pfx, "_perf_bursts"}, perf_bursts, 32'd0);
    check({pfx, "_perf_beats"},  perf_beats, 32'd0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0; enable = 1'b0; flush = 1'b0;
    fifo_empty = 1'b1; fifo_count = '0; fifo_dout = '0;
    m_awready = 1'b0; m_wready = 1'b0; m_bvalid = 1'b0; m_bresp = 2'b00;
    aw_mode = 0; w_mode = 0; b_rand = 0; wtog = 1'b0;
    model_reset(1'b1);
    #1;
    check_reset_outputs("rst");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  // One clock: drive inputs at the falling edge, check, then advance the model.
  task automatic cycle();
    bit stall, can_start;
    int avail, to4k;
    if (feed_left > 0 && q.size() < 31 && $urandom_range(0, 3) != 0) begin
      q.push_back({~word_seq, $urandom(), $urandom(), word_seq});
      word_seq++;
      feed_left--;
    end
    stall = (phase == 2) && (stall_left > 0) && (beats == stall_at);
    if (stall) stall_left--;
    fifo_empty = (q.size() == 0) || stall;
    fifo_dout  = (q.size() != 0) ? q[0] : '0;
    fifo_count = 5'(q.size());
    case (aw_mode)
      0:       m_awready = 1'b1;
      1:       m_awready = 1'($urandom_range(0, 1));
      default: m_awready = (phase == 1) && (aw_wait >= 3);
    endcase
    wtog = ~wtog;
    case (w_mode)
      0:       m_wready = 1'b1;
      1:       m_wready = wtog;
      default: m_wready = 1'($urandom_range(0, 1));
    endcase
    m_bvalid = (phase == 3) && ((b_rand == 0) || ($urandom_range(0, 1) == 1));
    m_bresp  = (burst_idx == err_on_burst) ? 2'b10 : {1'b0, 1'($urandom_range(0, 1))};
    #1;

    check("awsize", m_awsize, 3'd4);
    check("awburst", m_awburst, 2'b01);
    check("wstrb", m_wstrb, 16'hFFFF);
    check("wr_err", wr_err, exp_err);
    check("wvalid", m_wvalid, (phase == 2) && !fifo_empty);
    check("rd_en", fifo_rd_en, (phase == 2) && !fifo_empty && m_wready);
`ifdef AXI_WR_SCHED_PERF_EN
    check("perf_bursts", perf_bursts, exp_bursts);
    check("perf_beats", perf_beats, exp_beats);
`else
    check("perf_bursts", perf_bursts, 32'd0);
    check("perf_beats", perf_beats, 32'd0);
`endif
    if (fifo_rd_en === 1'b1) rd_en_cnt++;

    case (phase)
      0: begin
        check("idle_awvalid", m_awvalid, 1'b0);
        check("idle_bready", m_bready, 1'b0);
        check("idle_busy", busy, 1'b0);
        avail = q.size();
        can_start = enable && ((avail >= 16) || (flush && avail > 0));
        if (can_start) begin
          to4k = (4096 - int'(m_addr % 4096)) / 16;
          exp_len = avail;
          if (exp_len > 16)   exp_len = 16;
          if (exp_len > to4k) exp_len = to4k;
          phase = 1; aw_wait = 0;
        end
      end
      1: begin
        check("aw_awvalid", m_awvalid, 1'b1);
        check("aw_awaddr", m_awaddr, m_addr);
        check("aw_awlen", m_awlen, 8'(exp_len - 1));
        check("aw_bready", m_bready, 1'b0);
        check("aw_busy", busy, 1'b1);
        if (m_awready) begin
          aw_addr_log.push_back(m_awaddr);
          aw_len_log.push_back(int'(m_awlen));
          phase = 2; beats = 0;
        end else aw_wait++;
      end
      2: begin
        check("w_awvalid", m_awvalid, 1'b0);
        check("w_bready", m_bready, 1'b0);
        check("w_busy", busy, 1'b1);
        if (!fifo_empty) begin
          check("w_wdata", m_wdata, q[0]);
          check("w_wlast", m_wlast, beats == exp_len - 1);
          if (m_wready) begin
            void'(q.pop_front());
            beats++;
            if (beats == exp_len) phase = 3;
          end
        end
      end
      default: begin
        check("b_bready", m_bready, 1'b1);
        check("b_awvalid", m_awvalid, 1'b0);
        check("b_busy", busy, 1'b1);
        if (m_bvalid) begin
          if (m_bresp[1]) exp_err = 1;
          m_addr = m_addr + 32'(exp_len * 16);
          if (m_addr == BASE + REGION) m_addr = BASE;
          exp_bursts++; exp_beats += exp_len; burst_idx++;
          phase = 0;
        end
      end
    endcase
    @(negedge clk);
  endtask

  task automatic run_cycles(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  task automatic run_bursts(input int n, input int budget);
    int target = burst_idx + n;
    for (int i = 0; i < budget && burst_idx < target; i++) cycle();
    check("bursts_done", burst_idx, target);
  endtask

  initial begin
    rst_n = 1'b0;
    @(negedge clk);
    // Full burst at BASE, then a one-word flush burst shows the next address.
    do_reset();
    feed_left = 16;
    run_cycles(60);
    check("t1_fifo_count", fifo_count, 5'd16);
    enable = 1'b1;
    run_bursts(1, 200);
    check("t1_awaddr", aw_addr_log[0], 32'h0);
    check("t1_awlen", aw_len_log[0], 15);
    check("t1_pops", rd_en_cnt, 16);
    flush = 1'b1; feed_left = 1;
    run_bursts(1, 200);
    check("t1_next_addr", aw_addr_log[1], 32'h100);

    // Flush of a partial burst.
    do_reset();
    flush = 1'b1; feed_left = 5;
    run_cycles(40);
    enable = 1'b1;
    run_bursts(1, 200);
    check("t2_awlen", aw_len_log[0], 4);
    check("t2_fifo_empty", q.size(), 0);
    feed_left = 1;
    run_bursts(1, 200);
    check("t2_next_addr", aw_addr_log[1], 32'h50);

    // 4 KB clip at 0xFC0 with randomised handshakes.
    do_reset();
    aw_mode = 1; w_mode = 2; b_rand = 1;
    enable = 1'b1; feed_left = 240;
    run_bursts(15, 3000);
    enable = 1'b0; feed_left = 12;
    run_cycles(50);
    enable = 1'b1; flush = 1'b1;
    run_bursts(1, 300);
    flush = 1'b0; enable = 1'b0; feed_left = 20;
    run_cycles(80);
    enable = 1'b1;
    run_bursts(2, 600);
    check("t3_clip_addr", aw_addr_log[16], 32'hFC0);
    check("t3_clip_len", aw_len_log[16], 3);
    check("t3_page_addr", aw_addr_log[17], 32'h1000);
    check("t3_page_len", aw_len_log[17], 15);

    // Backpressure: late awready, toggling wready, FIFO gap mid-burst.
    do_reset();
    aw_mode = 2; w_mode = 1; stall_at = 5; stall_left = 2;
    feed_left = 16;
    run_cycles(60);
    enable = 1'b1;
    run_bursts(1, 300);
    check("t4_pops", rd_en_cnt, 16);
    check("t4_stall_seen", stall_left, 0);

    // Error response on the second burst and region wrap.
    do_reset();
    aw_mode = 1; w_mode = 2; b_rand = 1; err_on_burst = 1;
    enable = 1'b1; feed_left = 512;
    run_bursts(32, 6000);
    check("t5_addr0", aw_addr_log[0], 32'h0);
    check("t5_addr1", aw_addr_log[1], 32'h100);
    check("t5_addr31", aw_addr_log[31], 32'h1F00);
    check("t5_wr_err", wr_err, 1'b1);
    feed_left = 16;
    run_bursts(1, 400);
    check("t5_wrap_addr", aw_addr_log[32], BASE);
    check("t5_wr_err_held", wr_err, 1'b1);

    // Reset in the middle of the data phase.
    do_reset();
    feed_left = 16;
    run_cycles(60);
    enable = 1'b1; flush = 1'b1; feed_left = 0;
    for (int i = 0; i < 300 && !(phase == 2 && beats == 8); i++) cycle();
    check("t6_reached_beat8", beats, 8);
    rst_n = 1'b0;
    #1;
    check_reset_outputs("t6");
    model_reset(1'b0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    flush = 1'b0; feed_left = 8;
    run_bursts(1, 400);
    check("t6_restart_addr", aw_addr_log[0], BASE);
    check("t6_restart_len", aw_len_log[0], 15);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
